// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared constants and state encoding for the instruction memory loader
// Contents: ADDR_W/DATA_W/DEPTH defaults, BYTES_PER_WORD, FSM state codes.
package instr_loader_pkg;

  localparam int ADDR_W         = 12;
  localparam int DATA_W         = 17;
  localparam int DEPTH          = 512;
  localparam int BYTES_PER_WORD = 3;

  // Compared against the sampled len to reject oversized loads up front.
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_B0    = 3'd1;
  localparam state_t ST_B1    = 3'd2;
  localparam state_t ST_B2    = 3'd3;
  localparam state_t ST_WRITE = 3'd4;
  localparam state_t ST_CHECK = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - control, byte stream and memory write bundle of the loader
// slave modport: loader side (consumes start/len/stream, drives in_ready, we/wa/wd, busy/done/err).
// master modport: boot controller / stream source / memory side.
interface instr_mem_loader_if;

  logic                                start;
  logic [instr_loader_pkg::ADDR_W-1:0] len;
  logic                                in_valid;
  logic [7:0]                          in_data;
  logic                                in_ready;
  logic                                we;
  logic [instr_loader_pkg::ADDR_W-1:0] wa;
  logic [instr_loader_pkg::DATA_W-1:0] wd;
  logic                                busy;
  logic                                done;
  logic                                err;

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, we, wa, wd, busy, done, err
  );

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, we, wa, wd, busy, done, err
  );

endinterface

// File: rtl/instr_word_packer.sv
// rtl/instr_word_packer.sv - assembles three little-endian stream bytes into one 17-bit word
// Ports: clk, reset (async active-low), lane0_we/lane1_we capture bytes 0/1,
//        in_data current stream byte (used live as byte 2), word assembled word,
//        hi_ok high when in_data[7:1] is zero (legal third byte).
module instr_word_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lane0_we,
  input  logic              lane1_we,
  input  logic [7:0]        in_data,
  output logic [DATA_W-1:0] word,
  output logic              hi_ok
);

  logic [7:0] b0;
  logic [7:0] b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0 <= 8'd0;
      b1 <= 8'd0;
    end else begin
      if (lane0_we) b0 <= in_data;
      if (lane1_we) b1 <= in_data;
    end
  end

  // Third byte is taken straight from the stream so the word is ready on
  // the same beat that completes it.
  assign word  = {in_data[0], b1, b0};
  assign hi_ok = (in_data[7:1] == 7'd0);

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - streams a byte image into instruction memory, 3 bytes per 17-bit word
// Ports: clk, reset (async active-low), bus (instr_mem_loader_if.slave):
//        start/len load request, in_valid/in_data/in_ready byte stream,
//        we/wa/wd memory write port, busy/done/err status.
// Optional: INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module instr_mem_loader
  import instr_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  instr_mem_loader_if.slave   bus
);

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              byte_state;
  logic [DATA_W-1:0] packed_word;
  logic              hi_ok;

  assign byte_state = (state == ST_B0) || (state == ST_B1) || (state == ST_B2);

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign bus.in_ready = byte_state || (state == ST_CHECK);
`else
  assign bus.in_ready = byte_state;
`endif

  assign accept   = bus.in_valid && bus.in_ready;
  assign bus.we   = (state == ST_WRITE);
  assign bus.wa   = wa_q;
  assign bus.wd   = wd_q;
  assign bus.busy = (state != ST_IDLE) && (state != ST_DONE);
  assign bus.done = done_q;
  assign bus.err  = err_q;

  instr_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .lane0_we (accept && (state == ST_B0)),
    .lane1_we (accept && (state == ST_B1)),
    .in_data  (bus.in_data),
    .word     (packed_word),
    .hi_ok    (hi_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      len_q  <= '0;
      idx    <= '0;
      wa_q   <= '0;
      wd_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            len_q  <= bus.len;
            idx    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.len > DEPTH_W) begin
              // Oversized image: refuse without touching memory.
              state  <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (bus.len == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state  <= ST_CHECK;
`else
              state  <= ST_DONE;
              done_q <= 1'b1;
`endif
            end else begin
              state <= ST_B0;
            end
          end
        end
        ST_B0: if (accept) state <= ST_B1;
        ST_B1: if (accept) state <= ST_B2;
        ST_B2: begin
          if (accept) begin
            if (!hi_ok) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              wa_q  <= idx;
              wd_q  <= packed_word;
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          idx <= idx + ADDR_W'(1);
          if ((idx + ADDR_W'(1)) == len_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state  <= ST_CHECK;
`else
            state  <= ST_DONE;
            done_q <= 1'b1;
`endif
          end else begin
            state <= ST_B0;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            if (bus.in_data != csum) err_q <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  // Running XOR over every accepted data byte of the current load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= 8'd0;
    end else if (((state == ST_IDLE) || (state == ST_DONE)) && bus.start) begin
      csum <= 8'd0;
    end else if (accept && byte_state) begin
      csum <= csum ^ bus.in_data;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int DEPTH_TB = 512;

  typedef struct {
    logic [11:0] wa;
    logic [16:0] wd;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   last_we_cyc = -1000;

  wr_t        exp_q[$];
  logic [7:0] stim_q[$];

  instr_mem_loader_if bus ();

  instr_mem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse is matched against the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {3'b0, bus.wd, bus.wa[11:0]} & 32'h0, 32'h1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.wa), 32'(e.wa));
        chk("write_data", 32'(bus.wd), 32'(e.wd));
        chk("write_spacing_ge4", 32'((cycle - last_we_cyc) >= 4), 32'd1);
      end
      last_we_cyc = cycle;
    end
  end

  // Reference model: walk the byte image word by word.
  task automatic build_expect(input int n, output int cons, output bit e);
    logic [7:0] x;
    logic [7:0] b2;
    cons = 0;
    e = 1'b0;
    x = 8'h00;
    if (n > DEPTH_TB) begin
      e = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      b2 = stim_q[3*w+2];
      cons += 3;
      x = x ^ stim_q[3*w] ^ stim_q[3*w+1] ^ b2;
      if (b2[7:1] != 7'd0) begin
        e = 1'b1;
        return;
      end
      exp_q.push_back('{wa: 12'(w), wd: {b2[0], stim_q[3*w+1], stim_q[3*w]}});
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    cons += 1;
    if (stim_q[3*n] != x) e = 1'b1;
`endif
  endtask

  task automatic add_csum();
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (stim_q[i]) x = x ^ stim_q[i];
    stim_q.push_back(x);
`endif
  endtask

  task automatic gen_stim(input int n, input bit bad);
    int bw;
    logic [7:0] b2;
    stim_q.delete();
    bw = bad ? int'($urandom_range(n-1, 0)) : -1;
    for (int w = 0; w < n; w++) begin
      b2 = 8'($urandom_range(1, 0));
      if (w == bw) b2[7:1] = 7'($urandom_range(127, 1));
      stim_q.push_back(8'($urandom));
      stim_q.push_back(8'($urandom));
      stim_q.push_back(b2);
    end
    add_csum();
  endtask

  task automatic start_load(input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 12'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.len   = 12'($urandom);
  endtask

  // mode 0: valid always, 1: valid every other cycle, 2: random valid.
  task automatic feed(input int max_bytes, input int mode, input bit stop_on_done,
                      input bit spurious, output int consumed, output bit timed_out);
    int idx = 0;
    int cyc = 0;
    bit acc;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (stop_on_done && bus.done === 1'b1) break;
      if (!stop_on_done && idx >= max_bytes) break;
      if (cyc > 20000) begin
        timed_out = 1'b1;
        break;
      end
      bus.in_valid = (idx < max_bytes) && (idx < stim_q.size()) &&
                     ((mode == 0) || (mode == 1 && cyc % 2 == 0) ||
                      (mode == 2 && $urandom_range(1, 0) == 1));
      bus.in_data  = bus.in_valid ? stim_q[idx] : 8'($urandom);
      bus.start    = spurious && (bus.busy === 1'b1) && ($urandom_range(7, 0) == 0);
      bus.len      = 12'($urandom_range(4, 1));
      cyc++;
      #1;
      acc = bus.in_valid && (bus.in_ready === 1'b1);
      @(posedge clk);
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    consumed     = idx;
  endtask

  task automatic run_test(input string name, input int n, input int mode,
                          input bit spurious, input bit quick_done);
    int cons_exp, cons_act;
    bit err_exp, to;
    build_expect(n, cons_exp, err_exp);
    start_load(n);
    if (quick_done) begin
      @(negedge clk);
      chk({name, "_done_next_cycle"}, 32'(bus.done), 32'd1);
    end
    feed(stim_q.size(), mode, 1'b1, spurious, cons_act, to);
    chk({name, "_timeout"}, 32'(to), 32'd0);
    chk({name, "_done"}, 32'(bus.done), 32'd1);
    chk({name, "_err"}, 32'(bus.err), 32'(err_exp));
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({name, "_bytes_consumed"}, 32'(cons_act), 32'(cons_exp));
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cons;
    bit to;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_wa", 32'(bus.wa), 32'd0);
    chk("rst_wd", 32'(bus.wd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    // start -> in_ready next cycle
    stim_q = '{8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h00};
    add_csum();
    start_load(2);
    @(negedge clk);
    chk("in_ready_after_start", 32'(bus.in_ready), 32'd1);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    begin
      int ce; bit ee;
      build_expect(2, ce, ee);
      feed(stim_q.size(), 0, 1'b1, 1'b0, cons, to);
      chk("basic_done", 32'(bus.done), 32'd1);
      chk("basic_err", 32'(bus.err), 32'(ee));
      chk("basic_bytes", 32'(cons), 32'(ce));
      chk("basic_writes_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end

    stim_q = '{8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h00};
    add_csum();
    run_test("toggle_valid", 2, 1, 1'b0, 1'b0);

    stim_q = '{8'h34, 8'h12, 8'h02};
    run_test("bad_hi_bits", 1, 0, 1'b0, 1'b0);

    stim_q = '{8'h34, 8'h12, 8'h01};
    run_test("len_513", 513, 0, 1'b0, 1'b1);

    stim_q.delete();
    add_csum();
    run_test("len_0", 0, 0, 1'b0, 1'b0);

    // Reset in the middle of word 5 of a 10-word load.
    gen_stim(10, 1'b0);
    for (int w = 0; w < 5; w++)
      exp_q.push_back('{wa: 12'(w), wd: {stim_q[3*w+2][0], stim_q[3*w+1], stim_q[3*w]}});
    start_load(10);
    feed(17, 2, 1'b0, 1'b0, cons, to);
    chk("midrst_timeout", 32'(to), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_writes_before", 32'(exp_q.size()), 32'd0);
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_we", 32'(bus.we), 32'd0);
    chk("midrst_wa", 32'(bus.wa), 32'd0);
    chk("midrst_wd", 32'(bus.wd), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stim_q = '{8'h34, 8'h12, 8'h01};
    add_csum();
    run_test("after_rst", 1, 0, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int n;
      n = int'($urandom_range(6, 1));
      gen_stim(n, $urandom_range(3, 0) == 0);
      run_test($sformatf("rand%0d", t), n, int'($urandom_range(2, 0)), 1'b1, 1'b0);
    end

    gen_stim(DEPTH_TB, 1'b0);
    run_test("len_512", DEPTH_TB, 0, 1'b0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    stim_q = '{8'h34, 8'h12, 8'h01, 8'h27};
    run_test("csum_good", 1, 0, 1'b0, 1'b0);
    stim_q = '{8'h34, 8'h12, 8'h01, 8'h00};
    run_test("csum_bad", 1, 2, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
